// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
//   Shared Ethernet definitions for the RX header filter and the TX path.
//   - ETH_HDR_LEN : bytes in an untagged Ethernet header (dest, src, type)
//   - MAC_BCAST   : broadcast destination address
//   - eth_hdr_t   : parsed header fields, first wire byte in the MSBs
//   - rx_hdr_state_t : RX header filter FSM states
// ---------------------------------------------------------------------------
package eth_pkg;

    localparam int          ETH_HDR_LEN = 14;
    localparam logic [47:0] MAC_BCAST   = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } eth_hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HDR_OUT,
        PAYLOAD,
        DROP
    } rx_hdr_state_t;

endpackage

// File: rtl/eth_rx_hdr_filter_if.sv
// ---------------------------------------------------------------------------
// eth_rx_hdr_filter_if
//   8-bit AXI-Stream byte channel used for both the RX input and the payload
//   output of the header filter.
//   - tdata  : byte
//   - tvalid : byte present
//   - tready : sink can take the byte
//   - tlast  : last byte of the frame
//   - tuser  : bad-frame flag, meaningful with tlast
//
//   Handshake: a byte transfers on every rising clock edge where tvalid and
//   tready are both high. Once tvalid is raised the source holds tdata, tlast
//   and tuser stable until the transfer. tready may depend combinationally
//   on state but never on tvalid.
// ---------------------------------------------------------------------------
interface eth_rx_hdr_filter_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        input  tready,
        output tlast,
        output tuser
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready,
        input  tlast,
        input  tuser
    );

endinterface

// File: rtl/eth_mac_match.sv
// ---------------------------------------------------------------------------
// eth_mac_match
//   Combinational destination-MAC acceptance check, shared by RX and TX.
//   - dest      : destination MAC, first wire byte in [47:40]
//   - local_mac : local station address
//   - promisc   : accept everything
//   - mcast_en  : accept group addresses (I/G bit = dest[40])
//   - pass      : frame is accepted
//   ENABLE_MCAST=0 removes the multicast rule regardless of mcast_en.
// ---------------------------------------------------------------------------
module eth_mac_match
    import eth_pkg::*;
#(
    parameter bit ENABLE_MCAST = 1'b1
) (
    input  logic [47:0] dest,
    input  logic [47:0] local_mac,
    input  logic        promisc,
    input  logic        mcast_en,
    output logic        pass
);

    always_comb begin
        pass = promisc
             | (dest == local_mac)
             | (dest == MAC_BCAST)
             | (ENABLE_MCAST & mcast_en & dest[40]);
    end

endmodule

// File: rtl/eth_rx_hdr_filter.sv
// ---------------------------------------------------------------------------
// eth_rx_hdr_filter
//   Strips the 14-byte Ethernet header from the RX byte stream, presents it
//   on a registered header port, filters on destination MAC and forwards
//   the payload of accepted frames with zero latency. Rejected and short
//   frames are consumed silently, with a status pulse and a drop count.
//
//   Ports
//   - logic_clk, logic_rst : clock, asynchronous active-high reset
//   - s_axis               : RX byte stream from the MAC FIFO (slave)
//   - m_axis               : payload byte stream (master)
//   - m_hdr_valid/ready    : header handshake
//   - m_dest_mac, m_src_mac, m_eth_type : header fields, first byte in MSBs
//   - cfg_local_mac, cfg_promisc, cfg_mcast_en : filter configuration
//   - stat_drop_filter     : pulse, frame rejected by the MAC filter
//   - stat_drop_short      : pulse, frame ended before its first payload byte
//   - cnt_accept, cnt_drop : saturating frame counters
//   - dbg_state            : current FSM state
// ---------------------------------------------------------------------------
module eth_rx_hdr_filter
    import eth_pkg::*;
#(
    parameter int CNT_WIDTH    = 16,
    parameter bit ENABLE_MCAST = 1'b1
) (
    input  logic                 logic_clk,
    input  logic                 logic_rst,

    eth_rx_hdr_filter_if.slave   s_axis,
    eth_rx_hdr_filter_if.master  m_axis,

    output logic                 m_hdr_valid,
    input  logic                 m_hdr_ready,
    output logic [47:0]          m_dest_mac,
    output logic [47:0]          m_src_mac,
    output logic [15:0]          m_eth_type,

    input  logic [47:0]          cfg_local_mac,
    input  logic                 cfg_promisc,
    input  logic                 cfg_mcast_en,

    output logic                 stat_drop_filter,
    output logic                 stat_drop_short,
    output logic [CNT_WIDTH-1:0] cnt_accept,
    output logic [CNT_WIDTH-1:0] cnt_drop,

    output rx_hdr_state_t        dbg_state
);

    localparam logic [3:0] LAST_HDR_IDX = 4'(ETH_HDR_LEN - 1);

    rx_hdr_state_t  state_q, state_d;
    logic [3:0]     idx_q;
    // Holds header bytes 0..12; byte 13 is taken straight from the bus.
    logic [103:0]   hdr_sr_q;
    eth_hdr_t       hdr_q;
    logic           init_done_q;
    logic           drop_filter_q;
    logic           drop_short_q;
    logic [CNT_WIDTH-1:0] cnt_accept_q;
    logic [CNT_WIDTH-1:0] cnt_drop_q;

    logic           s_tready;
    logic           m_tvalid;
    logic           s_fire;
    logic           hdr_shift;
    logic           hdr_load;
    logic           short_evt;
    logic           filter_evt;
    logic           accept_evt;
    logic           drop_evt;
    logic           mac_pass;
    logic [47:0]    dest_cand;

    // With bytes 0..12 shifted in, dest bytes 0..5 sit in the top 48 bits.
    assign dest_cand = hdr_sr_q[103:56];

    eth_mac_match #(
        .ENABLE_MCAST (ENABLE_MCAST)
    ) u_mac_match (
        .dest      (dest_cand),
        .local_mac (cfg_local_mac),
        .promisc   (cfg_promisc),
        .mcast_en  (cfg_mcast_en),
        .pass      (mac_pass)
    );

    assign s_fire = s_axis.tvalid & s_tready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        s_tready   = 1'b0;
        m_tvalid   = 1'b0;
        m_hdr_valid = 1'b0;
        hdr_shift  = 1'b0;
        hdr_load   = 1'b0;
        short_evt  = 1'b0;
        filter_evt = 1'b0;
        accept_evt = 1'b0;
        drop_evt   = 1'b0;

        unique case (state_q)
            IDLE, HDR: begin
                // Held low for the first cycle out of reset.
                s_tready  = init_done_q;
                hdr_shift = s_fire;
                if (s_fire) begin
                    if (s_axis.tlast) begin
                        // Ends on or before byte 13: no payload, no header.
                        short_evt = 1'b1;
                        state_d   = IDLE;
                    end else if (idx_q == LAST_HDR_IDX) begin
                        hdr_load   = mac_pass;
                        filter_evt = ~mac_pass;
                        state_d    = mac_pass ? HDR_OUT : DROP;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR_OUT: begin
                m_hdr_valid = 1'b1;
                if (m_hdr_ready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                s_tready = m_axis.tready;
                m_tvalid = s_axis.tvalid;
                if (s_fire && s_axis.tlast) begin
                    accept_evt = 1'b1;
                    state_d    = IDLE;
                end
            end
            DROP: begin
                s_tready = 1'b1;
                if (s_fire && s_axis.tlast) begin
                    drop_evt = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Header capture, status pulses and counters
    // ------------------------------------------------------------------
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            idx_q         <= '0;
            hdr_sr_q      <= '0;
            hdr_q         <= '0;
            init_done_q   <= 1'b0;
            drop_filter_q <= 1'b0;
            drop_short_q  <= 1'b0;
            cnt_accept_q  <= '0;
            cnt_drop_q    <= '0;
        end else begin
            init_done_q   <= 1'b1;
            drop_filter_q <= filter_evt;
            drop_short_q  <= short_evt;

            if (hdr_shift) begin
                hdr_sr_q <= {hdr_sr_q[95:0], s_axis.tdata};
                idx_q    <= (s_axis.tlast || idx_q == LAST_HDR_IDX) ? 4'd0 : idx_q + 4'd1;
            end

            if (hdr_load) begin
                hdr_q <= {hdr_sr_q, s_axis.tdata};
            end

            if (accept_evt && cnt_accept_q != '1) begin
                cnt_accept_q <= cnt_accept_q + 1'b1;
            end

            // Short and filter drops are mutually exclusive in time; an OR
            // keeps any coincidence to a single increment.
            if ((short_evt || drop_evt) && cnt_drop_q != '1) begin
                cnt_drop_q <= cnt_drop_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axis.tready = s_tready;

    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tvalid = m_tvalid;
    assign m_axis.tlast  = (state_q == PAYLOAD) & s_axis.tlast;
    assign m_axis.tuser  = (state_q == PAYLOAD) & s_axis.tuser;

    assign m_dest_mac = hdr_q.dest_mac;
    assign m_src_mac  = hdr_q.src_mac;
    assign m_eth_type = hdr_q.eth_type;

    assign stat_drop_filter = drop_filter_q;
    assign stat_drop_short  = drop_short_q;
    assign cnt_accept       = cnt_accept_q;
    assign cnt_drop         = cnt_drop_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_eth_rx_hdr_filter.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_hdr_filter
//   Directed bench for eth_rx_hdr_filter. A second instance with CNT_WIDTH=4
//   shares the RX stream and is held in reset until the saturation step.
// ---------------------------------------------------------------------------
module tb_eth_rx_hdr_filter;
    import eth_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic logic_clk = 1'b0;
    logic logic_rst = 1'b1;
    logic rst4      = 1'b1;

    always #5 logic_clk = ~logic_clk;

    // ------------------------------------------------------------------
    // DUT wiring
    // ------------------------------------------------------------------
    eth_rx_hdr_filter_if s_if ();
    eth_rx_hdr_filter_if m_if ();
    eth_rx_hdr_filter_if s4_if ();
    eth_rx_hdr_filter_if m4_if ();

    logic          hdr_valid, hdr_ready;
    logic [47:0]   dest_mac, src_mac;
    logic [15:0]   eth_type;
    logic [47:0]   cfg_local_mac;
    logic          cfg_promisc, cfg_mcast_en;
    logic          stat_f, stat_s;
    logic [15:0]   cnt_acc, cnt_drop;
    rx_hdr_state_t dbg_state;

    logic          hdr_valid4;
    logic [47:0]   dest_mac4, src_mac4;
    logic [15:0]   eth_type4;
    logic          stat_f4, stat_s4;
    logic [3:0]    cnt_acc4, cnt_drop4;
    rx_hdr_state_t dbg_state4;

    eth_rx_hdr_filter #(.CNT_WIDTH(16), .ENABLE_MCAST(1'b1)) dut (
        .logic_clk        (logic_clk),
        .logic_rst        (logic_rst),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .m_hdr_valid      (hdr_valid),
        .m_hdr_ready      (hdr_ready),
        .m_dest_mac       (dest_mac),
        .m_src_mac        (src_mac),
        .m_eth_type       (eth_type),
        .cfg_local_mac    (cfg_local_mac),
        .cfg_promisc      (cfg_promisc),
        .cfg_mcast_en     (cfg_mcast_en),
        .stat_drop_filter (stat_f),
        .stat_drop_short  (stat_s),
        .cnt_accept       (cnt_acc),
        .cnt_drop         (cnt_drop),
        .dbg_state        (dbg_state)
    );

    assign s4_if.tdata  = s_if.tdata;
    assign s4_if.tvalid = s_if.tvalid;
    assign s4_if.tlast  = s_if.tlast;
    assign s4_if.tuser  = s_if.tuser;
    assign m4_if.tready = 1'b1;

    eth_rx_hdr_filter #(.CNT_WIDTH(4), .ENABLE_MCAST(1'b1)) dut4 (
        .logic_clk        (logic_clk),
        .logic_rst        (rst4),
        .s_axis           (s4_if),
        .m_axis           (m4_if),
        .m_hdr_valid      (hdr_valid4),
        .m_hdr_ready      (1'b1),
        .m_dest_mac       (dest_mac4),
        .m_src_mac        (src_mac4),
        .m_eth_type       (eth_type4),
        .cfg_local_mac    (cfg_local_mac),
        .cfg_promisc      (cfg_promisc),
        .cfg_mcast_en     (cfg_mcast_en),
        .stat_drop_filter (stat_f4),
        .stat_drop_short  (stat_s4),
        .cnt_accept       (cnt_acc4),
        .cnt_drop         (cnt_drop4),
        .dbg_state        (dbg_state4)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [9:0]   exp_q[$];   // {tuser, tlast, tdata}
    logic [111:0] hexp_q[$];  // {dest, src, type}
    logic [9:0]   exp_beat;
    logic [111:0] exp_hdr;
    int beats     = 0;
    int hdr_count = 0;
    int f_pulses  = 0;
    int s_pulses  = 0;
    logic mon_en  = 1'b0;
    logic stall_en = 1'b0;
    logic [7:0] pseed = 8'h11;

    task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor (samples at the falling edge)
    // ------------------------------------------------------------------
    always @(negedge logic_clk) begin
        if (!logic_rst && mon_en) begin
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_beat observed=%0h expected=none",
                           {m_if.tuser, m_if.tlast, m_if.tdata});
                end else begin
                    exp_beat = exp_q.pop_front();
                    chk("payload_beat", 112'({m_if.tuser, m_if.tlast, m_if.tdata}), 112'(exp_beat));
                    beats++;
                end
            end
            if (hdr_valid) begin
                chk("s_tready_in_hdr_out", 112'(s_if.tready), 112'(0));
                chk("m_tvalid_in_hdr_out", 112'(m_if.tvalid), 112'(0));
                if (hdr_ready) begin
                    if (hexp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL unexpected_hdr observed=%0h expected=none",
                               {dest_mac, src_mac, eth_type});
                    end else begin
                        exp_hdr = hexp_q.pop_front();
                        chk("hdr_fields", {dest_mac, src_mac, eth_type}, exp_hdr);
                        hdr_count++;
                    end
                end
            end
            if (stat_f) f_pulses++;
            if (stat_s) s_pulses++;
            chk("pulse_overlap", 112'(stat_f & stat_s), 112'(0));
        end
    end

    // ------------------------------------------------------------------
    // Downstream ready stalls, updated shortly after each rising edge
    // ------------------------------------------------------------------
    initial begin
        m_if.tready = 1'b1;
        hdr_ready   = 1'b1;
        forever begin
            @(posedge logic_clk);
            #2;
            if (stall_en) begin
                m_if.tready = ($urandom_range(0, 3) != 0);
                hdr_ready   = ($urandom_range(0, 2) != 0);
            end else begin
                m_if.tready = 1'b1;
                hdr_ready   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (entered just after a rising edge)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
        int guard = 0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        @(negedge logic_clk);
        while (!s_if.tready && guard < 300) begin
            guard++;
            @(negedge logic_clk);
        end
        if (!s_if.tready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=tready_low expected=handshake");
        end
        @(posedge logic_clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int len, input logic bad, input logic pass);
        logic [111:0] h;
        logic [7:0]   b;
        logic         last;
        h = {d, s, t};
        if (pass && len > ETH_HDR_LEN) hexp_q.push_back(h);
        for (int i = 0; i < len; i++) begin
            last = (i == len - 1);
            if (i < ETH_HDR_LEN) b = h[111 - 8*i -: 8];
            else                 b = 8'(pseed + 8'(i));
            if (pass && i >= ETH_HDR_LEN) exp_q.push_back({bad & last, last, b});
            send_byte(b, last, bad & last);
        end
        pseed = pseed + 8'd37;
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while ((exp_q.size() != 0 || hexp_q.size() != 0) && g < 3000) begin
            @(posedge logic_clk);
            #1;
            g++;
        end
        checks++;
        assert (exp_q.size() == 0 && hexp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain observed=%0d/%0d pending expected=0/0", tag, exp_q.size(), hexp_q.size());
        end
        repeat (2) @(posedge logic_clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    localparam logic [47:0] LOCAL = 48'h0200_0000_0001;
    localparam logic [47:0] SRC   = 48'h0A0B_0C0D_0E0F;

    int exp_beats;

    initial begin
        s_if.tdata    = 8'h00;
        s_if.tvalid   = 1'b0;
        s_if.tlast    = 1'b0;
        s_if.tuser    = 1'b0;
        cfg_local_mac = LOCAL;
        cfg_promisc   = 1'b0;
        cfg_mcast_en  = 1'b0;

        // Reset values (RX valid held high to expose any pass-through)
        repeat (3) @(posedge logic_clk);
        #1;
        s_if.tvalid = 1'b1;
        #1;
        chk("rst_hdr_valid", 112'(hdr_valid), 112'(0));
        chk("rst_m_tvalid",  112'(m_if.tvalid), 112'(0));
        chk("rst_s_tready",  112'(s_if.tready), 112'(0));
        chk("rst_fields",    {dest_mac, src_mac, eth_type}, 112'(0));
        chk("rst_pulses",    112'({stat_f, stat_s}), 112'(0));
        chk("rst_counters",  112'({cnt_acc, cnt_drop}), 112'(0));
        chk("rst_state",     112'(dbg_state), 112'(IDLE));
        s_if.tvalid = 1'b0;
        @(posedge logic_clk);
        #1;
        logic_rst = 1'b0;
        @(negedge logic_clk);
        chk("tready_first_cycle", 112'(s_if.tready), 112'(0));
        @(negedge logic_clk);
        chk("tready_idle", 112'(s_if.tready), 112'(1));
        @(posedge logic_clk);
        #1;
        mon_en = 1'b1;

        // 64-byte unicast frame to the local address
        send_frame(LOCAL, SRC, 16'h0800, 64, 1'b0, 1'b1);
        wait_drain("unicast");
        chk("t1_cnt_accept", 112'(cnt_acc), 112'(1));
        chk("t1_cnt_drop",   112'(cnt_drop), 112'(0));
        chk("t1_beats",      112'(beats), 112'(50));
        chk("t1_hdrs",       112'(hdr_count), 112'(1));

        // Broadcast passes, multicast with mcast disabled is filtered
        send_frame(MAC_BCAST, SRC, 16'h0806, 20, 1'b0, 1'b1);
        send_frame(48'h0100_5E00_0001, SRC, 16'h0800, 20, 1'b0, 1'b0);
        wait_drain("bcast_mcast");
        chk("t2_cnt_accept", 112'(cnt_acc), 112'(2));
        chk("t2_cnt_drop",   112'(cnt_drop), 112'(1));
        chk("t2_f_pulses",   112'(f_pulses), 112'(1));
        chk("t2_beats",      112'(beats), 112'(56));

        // Multicast enabled passes; promiscuous passes; near-miss unicast drops
        cfg_mcast_en = 1'b1;
        send_frame(48'h0100_5E00_0001, SRC, 16'h86DD, 16, 1'b0, 1'b1);
        cfg_mcast_en = 1'b0;
        cfg_promisc  = 1'b1;
        send_frame(48'h1234_5678_9ABC, SRC, 16'h0800, 15, 1'b0, 1'b1);
        cfg_promisc  = 1'b0;
        send_frame(48'h0200_0000_0002, SRC, 16'h0800, 15, 1'b0, 1'b0);
        wait_drain("cfg_rules");
        chk("t2b_cnt_accept", 112'(cnt_acc), 112'(4));
        chk("t2b_cnt_drop",   112'(cnt_drop), 112'(2));
        chk("t2b_f_pulses",   112'(f_pulses), 112'(2));
        chk("t2b_beats",      112'(beats), 112'(59));

        // Short frames: 10 bytes and exactly 14 bytes
        send_frame(LOCAL, SRC, 16'h0800, 10, 1'b0, 1'b0);
        send_frame(LOCAL, SRC, 16'h0800, 14, 1'b0, 1'b0);
        wait_drain("short");
        chk("t3_s_pulses",  112'(s_pulses), 112'(2));
        chk("t3_cnt_drop",  112'(cnt_drop), 112'(4));
        chk("t3_hdrs",      112'(hdr_count), 112'(4));
        chk("t3_f_pulses",  112'(f_pulses), 112'(2));

        // 100 back-to-back accepted frames with random downstream stalls
        stall_en  = 1'b1;
        exp_beats = 59;
        for (int k = 0; k < 100; k++) begin
            send_frame(LOCAL, 48'(SRC + 48'(k)), 16'(16'h0800 + k), 15 + (k % 26), 1'b0, 1'b1);
            exp_beats += 1 + (k % 26);
        end
        wait_drain("stall");
        stall_en = 1'b0;
        chk("t4_cnt_accept", 112'(cnt_acc), 112'(104));
        chk("t4_beats",      112'(beats), 112'(exp_beats));
        chk("t4_hdrs",       112'(hdr_count), 112'(104));

        // Bad-frame flag on tlast rides through on the last beat only
        send_frame(LOCAL, SRC, 16'h0800, 20, 1'b1, 1'b1);
        wait_drain("tuser");
        chk("t5_cnt_accept", 112'(cnt_acc), 112'(105));

        // Reset in the middle of the payload
        hexp_q.push_back({LOCAL, SRC, 16'h0800});
        begin
            logic [111:0] h;
            logic [7:0]   b;
            h = {LOCAL, SRC, 16'h0800};
            for (int i = 0; i < 19; i++) begin
                if (i < ETH_HDR_LEN) b = h[111 - 8*i -: 8];
                else begin
                    b = 8'(8'hC0 + 8'(i));
                    exp_q.push_back({1'b0, 1'b0, b});
                end
                send_byte(b, 1'b0, 1'b0);
            end
        end
        s_if.tdata  = 8'h5A;
        s_if.tvalid = 1'b1;
        logic_rst   = 1'b1;
        #1;
        chk("mid_rst_hdr_valid", 112'(hdr_valid), 112'(0));
        chk("mid_rst_m_tvalid",  112'(m_if.tvalid), 112'(0));
        chk("mid_rst_s_tready",  112'(s_if.tready), 112'(0));
        chk("mid_rst_state",     112'(dbg_state), 112'(IDLE));
        chk("mid_rst_fields",    {dest_mac, src_mac, eth_type}, 112'(0));
        chk("mid_rst_counters",  112'({cnt_acc, cnt_drop}), 112'(0));
        s_if.tvalid = 1'b0;
        @(posedge logic_clk);
        #1;
        logic_rst = 1'b0;
        repeat (2) @(posedge logic_clk);
        #1;
        send_frame(LOCAL, 48'h0A0B_0C0D_0E99, 16'h88B5, 30, 1'b0, 1'b1);
        wait_drain("post_rst");
        chk("t6_cnt_accept", 112'(cnt_acc), 112'(1));
        chk("t6_cnt_drop",   112'(cnt_drop), 112'(0));

        // Drop-counter saturation on the 4-bit instance
        rst4 = 1'b0;
        repeat (2) @(posedge logic_clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) send_frame(LOCAL, SRC, 16'h0800, 5, 1'b0, 1'b0);
            else            send_frame(48'h0200_0000_0099, SRC, 16'h0800, 18, 1'b0, 1'b0);
        end
        wait_drain("saturate");
        chk("t7_cnt_drop",    112'(cnt_drop), 112'(20));
        chk("t7_cnt_drop4",   112'(cnt_drop4), 112'(15));
        chk("t7_cnt_accept4", 112'(cnt_acc4), 112'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
